uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- UART receiver for the serial link feeding the MiniCalc2 calculator core.
- Converts the asynchronous RX pin into validated 8-bit bytes.
- Holds each byte in a one-deep buffer with a valid/acknowledge handshake.
- Reports framing and overrun errors.
- Sits between the board RX pad and the calculator's command input.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- OVERSAMPLE, 16, ticks per bit; must be even and >= 8.
- DATA_BITS, 8, data bits per frame; LSB first, no parity, 1 stop bit.

Ports:
- Clk  input  1  system clock, rising edge.
- ResetN  input  1  asynchronous active-low reset.
- RxWire  input  1  raw serial input; idle high; asynchronous to Clk.
- Data  output  DATA_BITS  last accepted byte; stable while DataValid=1.
- DataValid  output  1  buffer holds an unread byte.
- DataAck  input  1  consumer read strobe; honoured only when DataValid=1.
- FramingError  output  1  one-cycle pulse when the stop bit is sampled low.
- Overrun  output  1  sticky; a byte was dropped because the buffer was full.
- Busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, ResetN=0):
  - Data=0, DataValid=0, FramingError=0, Overrun=0, Busy=0.
  - FSM=IDLE; tick counter and bit counter cleared.
  - Both synchronizer flops reset to 1, so no false start is seen after reset.
  - A reset mid-frame abandons the frame.
- Input path: 2-flop synchronizer on RxWire gives rx_s. This adds 2 cycles of latency, which is accepted.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated, minimum 1.
  - Counter runs 0..DIV-1 and pulses tick for one cycle on wrap.
  - Counter is free-running and is restarted to 0 on the start-edge detect.
- FSM states and transitions:
  - IDLE: rx_s=0 → START; tick counter and sample counter cleared.
  - START: after OVERSAMPLE/2 ticks, sample rx_s.
    - 0 → DATA; bit index 0, sample counter cleared.
    - 1 → IDLE; glitch ignored, no error.
  - DATA: every OVERSAMPLE ticks, sample rx_s and shift it into the MSB of the shift register (LSB-first frame).
    - After DATA_BITS samples → STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - 1 → deliver the byte, then IDLE.
    - 0 → FramingError pulse, byte discarded, → BREAK.
  - BREAK: wait until rx_s=1, then IDLE. A held-low line produces exactly one error.
- Delivery (the clock after the stop sample):
  - DataValid=0: Data<=shift register, DataValid<=1.
  - DataValid=1 with DataAck=1 in the same cycle: the new byte is loaded, DataValid stays 1, no overrun.
  - DataValid=1 with DataAck=0: the new byte is dropped, old Data is kept, Overrun<=1.
- Handshake rules:
  - DataAck with DataValid=1 clears DataValid on the next edge and clears Overrun.
  - DataAck with DataValid=0 has no effect.
- Busy = (state != IDLE).
- Latency: the start edge on RxWire to DataValid rising is 2 + (OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE)·DIV + 1 clocks, ±DIV.
- Back-to-back frames: after a valid stop sample the FSM returns to IDLE at mid-stop-bit. It must catch a start bit beginning at the end of that stop bit.

Decomposition:
- Shared package uart_pkg:
  - State encoding enum: IDLE, START, DATA, STOP, BREAK.
  - Function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE, with a floor of 1.
  - Framing constants: start=0, stop=1.
- Sub-module uart_baud_tick:
  - Parameterised divider with a synchronous restart input and a tick output.
  - Reusable later by the planned uart_tx_byte.

Test Plan (bench parameters: CLK_FREQ=3200000, BAUD=100000, OVERSAMPLE=16 → DIV=2, 32 clocks/bit):
1. Send 0xA5 as a clean frame, DataAck held 0 → DataValid rises once; Data=0xA5; FramingError and Overrun stay 0; Busy back to 0 after the frame.
2. Send 0x3C and 0x7E back-to-back; DataAck pulses 1 cycle as soon as each DataValid rises → consumer reads 0x3C then 0x7E; Overrun=0.
3. Send 0x11 and 0x22 with no DataAck → Data stays 0x11; Overrun=1 after the second stop bit. A later DataAck clears both DataValid and Overrun.
4. Send 0x55 with the stop bit forced low, then the line high → one FramingError pulse, DataValid stays 0. A following 0x0F is received correctly.
5. Apply a 10-clock low glitch on an idle line → FSM returns to IDLE; no DataValid, no FramingError.
6. Assert ResetN=0 mid-data-bit of a frame, release it, then send 0xC3 → all outputs 0 during reset; only 0xC3 is delivered afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, framing levels and the
// baud divider calculation used by the receive (and future transmit) path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Clocks per oversample tick, truncated, never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int div_v;
    div_v = clk_freq / (baud * oversample);
    if (div_v < 1) begin
      div_v = 1;
    end else begin
      div_v = div_v;
    end
    return div_v;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider with a synchronous restart, shared
// by UART receive and transmit blocks.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Divider counter; tick fires for one cycle on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (restart) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + ONE;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver: synchronizes RxWire, decodes 8N1 frames with oversampling,
// and presents bytes through a one-deep valid/ack buffer with error flags.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 RxWire,
  output logic [DATA_BITS-1:0] Data,
  output logic                 DataValid,
  input  logic                 DataAck,
  output logic                 FramingError,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_ONE    = BW'(1);

  logic                 sync1_r, sync2_r, rx_s;
  uart_state_e          state_r, state_nxt_s;
  logic                 tick_s;
  logic [TW-1:0]        tick_cnt_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 half_done_s, full_done_s;
  logic                 restart_s, cnt_clr_s, bit_clr_s, shift_en_s;
  logic                 stop_ok_s, stop_fail_s;
  logic                 deliver_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r, fe_r, ovr_r, busy_r;

  // Two-flop synchronizer; resets to the idle level so no false start appears.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= RxWire;
      sync2_r <= sync1_r;
    end
  end
  assign rx_s = sync2_r;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (Clk),
    .rst_n   (ResetN),
    .restart (restart_s),
    .tick    (tick_s)
  );

  assign half_done_s = tick_s && (tick_cnt_r == HALF_M1);
  assign full_done_s = tick_s && (tick_cnt_r == FULL_M1);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_s == START_BIT) state_nxt_s = ST_START;
        else                   state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (half_done_s) state_nxt_s = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
        else             state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (full_done_s && (bit_cnt_r == LAST_BIT)) state_nxt_s = ST_STOP;
        else                                        state_nxt_s = ST_DATA;
      end
      ST_STOP: begin
        if (full_done_s) state_nxt_s = (rx_s == STOP_BIT) ? ST_IDLE : ST_BREAK;
        else             state_nxt_s = ST_STOP;
      end
      ST_BREAK: begin
        if (rx_s == STOP_BIT) state_nxt_s = ST_IDLE;
        else                  state_nxt_s = ST_BREAK;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state strobes controlling the counters, shifter and delivery.
  always_comb begin
    restart_s   = 1'b0;
    cnt_clr_s   = 1'b0;
    bit_clr_s   = 1'b0;
    shift_en_s  = 1'b0;
    stop_ok_s   = 1'b0;
    stop_fail_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        restart_s = (rx_s == START_BIT);
        cnt_clr_s = 1'b1;
        bit_clr_s = 1'b1;
      end
      ST_START: begin
        cnt_clr_s = half_done_s;
        bit_clr_s = half_done_s;
      end
      ST_DATA: begin
        cnt_clr_s  = full_done_s;
        shift_en_s = full_done_s;
      end
      ST_STOP: begin
        stop_ok_s   = full_done_s && (rx_s == STOP_BIT);
        stop_fail_s = full_done_s && (rx_s != STOP_BIT);
      end
      ST_BREAK: begin
        cnt_clr_s = 1'b1;
      end
      default: begin
        cnt_clr_s = 1'b1;
        bit_clr_s = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      tick_cnt_r <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
    end else begin
      if (cnt_clr_s)   tick_cnt_r <= '0;
      else if (tick_s) tick_cnt_r <= tick_cnt_r + T_ONE;
      else             tick_cnt_r <= tick_cnt_r;
      if (bit_clr_s)       bit_cnt_r <= '0;
      else if (shift_en_s) bit_cnt_r <= bit_cnt_r + B_ONE;
      else                 bit_cnt_r <= bit_cnt_r;
      // LSB arrives first, so each new bit enters at the top and moves down.
      if (shift_en_s) shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
      else            shift_r <= shift_r;
    end
  end

  // Output buffer: a delivered byte may replace an unread one only when it is acked in the same cycle.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      deliver_r <= 1'b0;
      data_r    <= '0;
      valid_r   <= 1'b0;
      fe_r      <= 1'b0;
      ovr_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      deliver_r <= stop_ok_s;
      fe_r      <= stop_fail_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      if (deliver_r) begin
        if (!valid_r) begin
          data_r  <= shift_r;
          valid_r <= 1'b1;
        end else if (DataAck) begin
          data_r  <= shift_r;
          valid_r <= 1'b1;
          ovr_r   <= 1'b0;
        end else begin
          ovr_r   <= 1'b1;
        end
      end else if (DataAck && valid_r) begin
        valid_r <= 1'b0;
        ovr_r   <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign Data         = data_r;
  assign DataValid    = valid_r;
  assign FramingError = fe_r;
  assign Overrun      = ovr_r;
  assign Busy         = busy_r;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed plus randomized bench for uart_rx_byte; expected bytes and error
// counts come from a frame-level model of the serial link.
module tb_uart_rx_byte;

  localparam int CLK_FREQ = 3200000;
  localparam int BAUD     = 100000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CLK_FREQ / BAUD;

  logic       Clk = 1'b0;
  logic       ResetN = 1'b0;
  logic       RxWire = 1'b1;
  logic       DataAck = 1'b0;
  logic [7:0] Data;
  logic       DataValid, FramingError, Overrun, Busy;

  int   total = 0;
  int   bad = 0;
  int   fe_cnt = 0;
  int   dv_rise = 0;
  logic dv_prev = 1'b0;
  bit   auto_ack = 1'b0;
  bit   abort_tx = 1'b0;
  logic busy_mid = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always #5 Clk = ~Clk;

  uart_rx_byte #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8)
  ) dut (
    .Clk(Clk), .ResetN(ResetN), .RxWire(RxWire), .Data(Data),
    .DataValid(DataValid), .DataAck(DataAck), .FramingError(FramingError),
    .Overrun(Overrun), .Busy(Busy)
  );

  // Event counters observed on the falling edge.
  always @(negedge Clk) begin
    if (FramingError === 1'b1) fe_cnt++;
    if (DataValid === 1'b1 && dv_prev !== 1'b1) dv_rise++;
    dv_prev = DataValid;
  end

  // Automatic consumer: reads and acks a byte as soon as it is offered.
  initial begin
    forever begin
      @(negedge Clk);
      if (auto_ack) begin
        if (DataValid === 1'b1 && DataAck == 1'b0) begin
          got.push_back(Data);
          DataAck = 1'b1;
        end else begin
          DataAck = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  function automatic logic [7:0] q_at(input int i);
    if (i < got.size()) return got[i];
    else                return 8'hxx;
  endfunction

  // Start bit, eight data bits LSB first, then the given stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (abort_tx) begin
          RxWire = 1'b1;
          return;
        end
        @(negedge Clk);
        RxWire = fr[i];
        if (i == 4 && c == 16) busy_mid = Busy;
      end
    end
  endtask

  task automatic manual_ack();
    @(negedge Clk);
    DataAck = 1'b1;
    @(negedge Clk);
    DataAck = 1'b0;
  endtask

  initial begin
    int f0, d0, fe_exp, gap;
    logic [7:0] b;
    bit good;

    // Reset state
    idle(3);
    check("rst_data", {24'd0, Data}, 32'd0);
    check("rst_valid", {31'd0, DataValid}, 32'd0);
    check("rst_fe", {31'd0, FramingError}, 32'd0);
    check("rst_ovr", {31'd0, Overrun}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    ResetN = 1'b1;
    idle(5);

    // 1: clean frame, no ack
    send_frame(8'hA5, 1'b1);
    idle(40);
    check("t1_rise", dv_rise, 32'd1);
    check("t1_data", {24'd0, Data}, 32'hA5);
    check("t1_valid", {31'd0, DataValid}, 32'd1);
    check("t1_fe", fe_cnt, 32'd0);
    check("t1_ovr", {31'd0, Overrun}, 32'd0);
    check("t1_busy_mid", {31'd0, busy_mid}, 32'd1);
    check("t1_busy_end", {31'd0, Busy}, 32'd0);
    manual_ack();
    check("t1_ack_valid", {31'd0, DataValid}, 32'd0);

    // 2: back-to-back with immediate acks
    got.delete();
    auto_ack = 1'b1;
    send_frame(8'h3C, 1'b1);
    send_frame(8'h7E, 1'b1);
    idle(40);
    auto_ack = 1'b0;
    check("t2_count", got.size(), 32'd2);
    check("t2_b0", {24'd0, q_at(0)}, 32'h3C);
    check("t2_b1", {24'd0, q_at(1)}, 32'h7E);
    check("t2_ovr", {31'd0, Overrun}, 32'd0);
    check("t2_valid", {31'd0, DataValid}, 32'd0);

    // 3: overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(40);
    check("t3_data", {24'd0, Data}, 32'h11);
    check("t3_valid", {31'd0, DataValid}, 32'd1);
    check("t3_ovr", {31'd0, Overrun}, 32'd1);
    manual_ack();
    check("t3_ack_valid", {31'd0, DataValid}, 32'd0);
    check("t3_ack_ovr", {31'd0, Overrun}, 32'd0);

    // 4: framing error with held-low line, then recovery
    f0 = fe_cnt;
    d0 = dv_rise;
    send_frame(8'h55, 1'b0);
    idle(64);
    RxWire = 1'b1;
    idle(40);
    check("t4_fe_once", fe_cnt - f0, 32'd1);
    check("t4_no_rise", dv_rise - d0, 32'd0);
    check("t4_valid", {31'd0, DataValid}, 32'd0);
    check("t4_busy", {31'd0, Busy}, 32'd0);
    send_frame(8'h0F, 1'b1);
    idle(40);
    check("t4_data", {24'd0, Data}, 32'h0F);
    check("t4_valid2", {31'd0, DataValid}, 32'd1);
    manual_ack();

    // 5: short glitch on idle line
    f0 = fe_cnt;
    d0 = dv_rise;
    RxWire = 1'b0;
    idle(10);
    RxWire = 1'b1;
    idle(60);
    check("t5_rise", dv_rise - d0, 32'd0);
    check("t5_fe", fe_cnt - f0, 32'd0);
    check("t5_busy", {31'd0, Busy}, 32'd0);

    // 6: reset in the middle of a frame
    send_frame(8'hE7, 1'b1);
    idle(10);
    check("t6_pre_valid", {31'd0, DataValid}, 32'd1);
    fork
      send_frame(8'h99, 1'b1);
      begin
        idle(100);
        abort_tx = 1'b1;
        ResetN = 1'b0;
        idle(2);
        check("t6_rst_data", {24'd0, Data}, 32'd0);
        check("t6_rst_valid", {31'd0, DataValid}, 32'd0);
        check("t6_rst_ovr", {31'd0, Overrun}, 32'd0);
        check("t6_rst_fe", {31'd0, FramingError}, 32'd0);
        check("t6_rst_busy", {31'd0, Busy}, 32'd0);
        ResetN = 1'b1;
      end
    join
    abort_tx = 1'b0;
    RxWire = 1'b1;
    idle(40);
    d0 = dv_rise;
    got.delete();
    auto_ack = 1'b1;
    send_frame(8'hC3, 1'b1);
    idle(40);
    auto_ack = 1'b0;
    check("t6_count", got.size(), 32'd1);
    check("t6_byte", {24'd0, q_at(0)}, 32'hC3);
    check("t6_rise", dv_rise - d0, 32'd1);

    // Random frames: good ones must arrive in order, bad stops count one error each
    f0 = fe_cnt;
    fe_exp = 0;
    got.delete();
    exp_q.delete();
    auto_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good);
      if (good) begin
        exp_q.push_back(b);
        gap = $urandom_range(0, 20);
      end else begin
        fe_exp++;
        RxWire = 1'b1;
        gap = 8 + $urandom_range(0, 20);
      end
      idle(gap);
    end
    idle(40);
    auto_ack = 1'b0;
    check("rnd_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rnd_byte%0d", i), {24'd0, q_at(i)}, {24'd0, exp_q[i]});
    end
    check("rnd_fe", fe_cnt - f0, fe_exp);
    check("rnd_ovr", {31'd0, Overrun}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
